pong_engine: RTL

PONG_ENGINE -- requirements
Module: pong_engine

---
 rtl/pong_engine.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_engine.sv
// Pong game engine: frame-tick driven game state, ball/paddle physics and a registered pixel colour stage.
// state     | meaning
// IDLE      | waiting for btn_start
// SERVE     | ball held for SERVE_FRAMES ticks, paddles free
// PLAY      | ball and paddles moving
// POINT     | one tick to award the point
// GAME_OVER | winner reached WIN_SCORE, waiting for btn_start
module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_ISPX    = 5,
  parameter int BALL_ISPY    = 3,
  parameter int PAD_HEIGHT   = 48,
  parameter int PAD_WIDTH    = 10,
  parameter int PAD_OFFS     = 32,
  parameter int PAD_SPY      = 3,
  parameter int SPEEDUP      = 5,
  parameter int SPX_MAX      = 12,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int TWO_PLAYER   = 0
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn2_up,
  input  logic       btn2_dn,
  input  logic       btn_start,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       blank,
  output logic [3:0] RED,
  output logic [3:0] GREEN,
  output logic [3:0] BLUE,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam logic [10:0] BS         = 11'(BALL_SIZE);
  localparam logic [10:0] PH         = 11'(PAD_HEIGHT);
  localparam logic [10:0] PH_HALF    = 11'(PAD_HEIGHT / 2);
  localparam logic [10:0] PSPY       = 11'(PAD_SPY);
  localparam logic [10:0] BALL_XL    = 11'(PAD_OFFS + PAD_WIDTH);
  localparam logic [10:0] BALL_XR    = 11'(H_RES - PAD_OFFS - PAD_WIDTH - BALL_SIZE);
  localparam logic [10:0] BALL_Y0    = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] PAD_Y0     = 11'((V_RES - PAD_HEIGHT) / 2);
  localparam logic [10:0] PAD_YMAX   = 11'(V_RES - PAD_HEIGHT - 1);
  localparam logic [10:0] X_EDGE_R   = 11'(H_RES - 1);
  localparam logic [10:0] X_PAD_R    = 11'(H_RES - PAD_OFFS - PAD_WIDTH - 1);
  localparam logic [10:0] X_BALL_MAX = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0] Y_EDGE     = 11'(V_RES - 1);
  localparam logic [10:0] PADL_X0    = 11'(PAD_OFFS);
  localparam logic [10:0] PADL_X1    = 11'(PAD_OFFS + PAD_WIDTH);
  localparam logic [10:0] PADR_X0    = 11'(H_RES - PAD_OFFS - PAD_WIDTH);
  localparam logic [10:0] PADR_X1    = 11'(H_RES - PAD_OFFS);
  localparam logic [10:0] SPX0       = 11'(BALL_ISPX);
  localparam logic [10:0] SPY0       = 11'(BALL_ISPY);
  localparam logic [10:0] SPXMAX     = 11'(SPX_MAX);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]  HIT_LAST   = 4'(SPEEDUP - 1);
  localparam logic [15:0] SERVE_LOAD = 16'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_t;

  state_t      state;
  logic [10:0] ball_x, ball_y, padl_y, padr_y, spx, spy;
  logic [3:0]  hit_cnt;
  logic [15:0] serve_cnt;
  logic        dir_r, dir_d, scorer_l;

  logic [10:0] bx_n, by_n, padl_n, padr_n, xe, ye;
  logic        dr_n, dd_n, hit, pt, pt_left, ovl_l, ovl_r;
  logic        ai_up, ai_dn, r_up, r_dn, won;
  logic [3:0]  sl_inc, sr_inc;
  logic        in_ball, in_padl, in_padr;

  function automatic logic [10:0] pad_next(input logic [10:0] p, input logic up, input logic dn);
    logic [10:0] r;
    r = p;
    if (up && !dn)      r = (p < PSPY) ? 11'd0 : p - PSPY;
    else if (dn && !up) r = (p + PSPY > PAD_YMAX) ? PAD_YMAX : p + PSPY;
    return r;
  endfunction

  always_comb begin
    ovl_l = (ball_y + BS >= padl_y) && (ball_y <= padl_y + PH);
    ovl_r = (ball_y + BS >= padr_y) && (ball_y <= padr_y + PH);
    ai_dn = (padr_y + PH_HALF < ball_y);
    ai_up = (padr_y + PH_HALF > ball_y + BS);
    if (TWO_PLAYER != 0) begin
      r_up = btn2_up;
      r_dn = btn2_dn;
    end else begin
      r_up = ai_up;
      r_dn = ai_dn;
    end
    padl_n = pad_next(padl_y, btn_up, btn_dn);
    padr_n = pad_next(padr_y, r_up, r_dn);

    bx_n    = ball_x;
    dr_n    = dir_r;
    hit     = 1'b0;
    pt      = 1'b0;
    pt_left = 1'b0;
    // wall test always wins over the paddle test on both sides
    if (dir_r) begin
      if (ball_x + BS + spx >= X_EDGE_R) begin
        bx_n    = X_BALL_MAX;
        pt      = 1'b1;
        pt_left = 1'b1;
      end else if ((ball_x + BS + spx >= X_PAD_R) && ovl_r) begin
        dr_n = 1'b0;
        hit  = 1'b1;
      end else begin
        bx_n = ball_x + spx;
      end
    end else begin
      if (ball_x < spx) begin
        bx_n = 11'd0;
        pt   = 1'b1;
      end else if ((ball_x - spx <= BALL_XL) && ovl_l) begin
        dr_n = 1'b1;
        hit  = 1'b1;
      end else begin
        bx_n = ball_x - spx;
      end
    end

    by_n = ball_y;
    dd_n = dir_d;
    if (dir_d) begin
      if (ball_y + BS + spy >= Y_EDGE) dd_n = 1'b0;
      else                             by_n = ball_y + spy;
    end else begin
      if (ball_y < spy) dd_n = 1'b1;
      else              by_n = ball_y - spy;
    end

    sl_inc = (score_l >= WIN) ? score_l : score_l + 4'd1;
    sr_inc = (score_r >= WIN) ? score_r : score_r + 4'd1;
    won    = scorer_l ? (sl_inc == WIN) : (sr_inc == WIN);
  end

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      state     <= IDLE;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
      hit_cnt   <= 4'd0;
      padl_y    <= PAD_Y0;
      padr_y    <= PAD_Y0;
      ball_x    <= BALL_XL;
      ball_y    <= BALL_Y0;
      spx       <= SPX0;
      spy       <= SPY0;
      dir_r     <= 1'b1;
      dir_d     <= 1'b1;
      serve_cnt <= SERVE_LOAD;
      scorer_l  <= 1'b0;
    end else if (frame_tick) begin
      unique case (state)
        IDLE: if (btn_start) begin
          score_l   <= 4'd0;
          score_r   <= 4'd0;
          padl_y    <= PAD_Y0;
          padr_y    <= PAD_Y0;
          ball_x    <= BALL_XL;
          dir_r     <= 1'b1;
          ball_y    <= BALL_Y0;
          dir_d     <= 1'b1;
          spx       <= SPX0;
          spy       <= SPY0;
          hit_cnt   <= 4'd0;
          serve_cnt <= SERVE_LOAD;
          state     <= SERVE;
        end
        SERVE: begin
          padl_y <= padl_n;
          padr_y <= padr_n;
          if (serve_cnt == 16'd0) state <= PLAY;
          else                    serve_cnt <= serve_cnt - 16'd1;
        end
        PLAY: begin
          padl_y <= padl_n;
          padr_y <= padr_n;
          ball_x <= bx_n;
          ball_y <= by_n;
          dir_r  <= dr_n;
          dir_d  <= dd_n;
          if (hit) begin
            if (hit_cnt == HIT_LAST) begin
              hit_cnt <= 4'd0;
              spx     <= (spx >= SPXMAX) ? SPXMAX : spx + 11'd1;
            end else begin
              hit_cnt <= hit_cnt + 4'd1;
            end
          end
          if (pt) begin
            scorer_l <= pt_left;
            state    <= POINT;
          end
        end
        POINT: begin
          if (scorer_l) score_l <= sl_inc;
          else          score_r <= sr_inc;
          if (won) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            // the player who lost the point serves
            ball_x    <= scorer_l ? BALL_XR : BALL_XL;
            dir_r     <= !scorer_l;
            ball_y    <= BALL_Y0;
            dir_d     <= 1'b1;
            spx       <= SPX0;
            spy       <= SPY0;
            hit_cnt   <= 4'd0;
            serve_cnt <= SERVE_LOAD;
            state     <= SERVE;
          end
        end
        GAME_OVER: if (btn_start) begin
          state     <= IDLE;
          game_over <= 1'b0;
          score_l   <= 4'd0;
          score_r   <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign in_ball = (xe >= ball_x) && (xe < ball_x + BS) && (ye >= ball_y) && (ye < ball_y + BS);
  assign in_padl = (xe >= PADL_X0) && (xe < PADL_X1) && (ye >= padl_y) && (ye < padl_y + PH);
  assign in_padr = (xe >= PADR_X0) && (xe < PADR_X1) && (ye >= padr_y) && (ye < padr_y + PH);

  always_ff @(posedge clk) begin
    if (btn_reset)                 {RED, GREEN, BLUE} <= 12'h000;
    else if (blank)                {RED, GREEN, BLUE} <= 12'h000;
    else if (in_ball)              {RED, GREEN, BLUE} <= 12'h0F0;
    else if (in_padl || in_padr)   {RED, GREEN, BLUE} <= 12'hFFF;
    else if (state == GAME_OVER)   {RED, GREEN, BLUE} <= 12'h400;
    else                           {RED, GREEN, BLUE} <= 12'h000;
  end

endmodule
